// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGW-1:0] digit,
    output logic [DIGW-1:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock)
// feeding the multi-digit 7-segment display driver.
//
//   state | meaning
//   IDLE  | waiting for start; bcd/overflow hold the last result
//   SHIFT | one add-3 + shift step per edge, cnt counts remaining bits
//   DONE  | publish scratch digits to bcd, pulse done
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int NDIG  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     bin_in,
    output logic                 busy,
    output logic                 done,
    output logic [NDIG*DIGW-1:0] bcd,
    output logic                 overflow
);

    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam longint unsigned LIMIT = pow10(NDIG) - 1;
    localparam int LIMW = $clog2(LIMIT + 2);

    state_t                  state;
    logic [WIDTH-1:0]        shreg;
    logic [NDIG*DIGW-1:0]    digits;
    logic [NDIG*DIGW-1:0]    adj;
    logic [CNTW-1:0]         cnt;
    logic                    ovf_pend;
    logic                    ovf_next;
    logic [NDIG*DIGW+WIDTH:0] step_vec;
    logic                    carry_unused;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit   (digits[g*DIGW +: DIGW]),
            .adjusted(adj[g*DIGW +: DIGW])
        );
    end

    // The bit shifted out of the top digit is dropped: result is bin_in mod 10^NDIG.
    assign step_vec     = {adj, shreg, 1'b0};
    assign carry_unused = step_vec[NDIG*DIGW+WIDTH];

    // Too few input bits to ever reach 10^NDIG means overflow cannot occur.
    if (LIMW > WIDTH) begin : g_no_ovf
        assign ovf_next = 1'b0;
    end else begin : g_ovf
        assign ovf_next = bin_in > WIDTH'(LIMIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            digits   <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        shreg    <= bin_in;
                        digits   <= '0;
                        cnt      <= CNTW'(WIDTH - 1);
                        ovf_pend <= ovf_next;
                    end
                end
                SHIFT: begin
                    digits <= step_vec[NDIG*DIGW+WIDTH-1:WIDTH];
                    shreg  <= step_vec[WIDTH-1:0];
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    bcd      <= digits;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed vector table, multi-cycle
// corner sequences and a random sweep against a decimal reference.
module tb_bin_to_bcd_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] last_bcd = 16'h0000;
    logic        last_ovf = 1'b0;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
        string       name;
    } vec_t;

    vec_t vecs[12];

    bin_to_bcd_seq #(.WIDTH(14), .NDIG(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        int r;
        r = v % 10000;
        return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    // One full conversion: accepting edge E0, then 15 edges to the done pulse.
    task automatic run_conv(input logic [13:0] v, input logic [15:0] eb, input logic eo,
                            input bit scramble, input string name);
        int lat_err;
        int hold_err;
        lat_err  = 0;
        hold_err = 0;
        @(negedge clock);
        bin_in = v;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (busy !== 1'b1 || done !== 1'b0) lat_err++;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clock);
            #1;
            if (scramble) bin_in = 14'($urandom);
            if (k < 15) begin
                if (done !== 1'b0 || busy !== 1'b1) lat_err++;
                if (bcd !== last_bcd || overflow !== last_ovf) hold_err++;
            end
        end
        check({name, " done"}, {31'd0, done}, 32'd1);
        check({name, " busy"}, {31'd0, busy}, 32'd0);
        check({name, " bcd"}, {16'd0, bcd}, {16'd0, eb});
        check({name, " overflow"}, {31'd0, overflow}, {31'd0, eo});
        check({name, " latency"}, lat_err, 0);
        check({name, " hold"}, hold_err, 0);
        last_bcd = eb;
        last_ovf = eo;
    endtask

    initial begin
        int done_cnt;
        logic [13:0] rv;

        vecs[0]  = '{14'd0,     16'h0000, 1'b0, "zero"};
        vecs[1]  = '{14'd1234,  16'h1234, 1'b0, "nominal_1234"};
        vecs[2]  = '{14'd9999,  16'h9999, 1'b0, "max_9999"};
        vecs[3]  = '{14'd16383, 16'h6383, 1'b1, "full_16383"};
        vecs[4]  = '{14'd10000, 16'h0000, 1'b1, "wrap_10000"};
        vecs[5]  = '{14'd1,     16'h0001, 1'b0, "one"};
        vecs[6]  = '{14'd10,    16'h0010, 1'b0, "ten"};
        vecs[7]  = '{14'd99,    16'h0099, 1'b0, "n99"};
        vecs[8]  = '{14'd100,   16'h0100, 1'b0, "n100"};
        vecs[9]  = '{14'd5005,  16'h5005, 1'b0, "n5005"};
        vecs[10] = '{14'd8421,  16'h8421, 1'b0, "n8421"};
        vecs[11] = '{14'd10001, 16'h0001, 1'b1, "wrap_10001"};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset bcd", {16'd0, bcd}, 32'd0);
        check("reset overflow", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, 1'b0, vecs[i].name);
        end

        run_conv(14'd505, 16'h0505, 1'b0, 1'b1, "bin_in_stable");

        // start held high: 777 arrives mid-conversion and is taken only in the done cycle
        @(negedge clock);
        bin_in = 14'd42;
        start  = 1'b1;
        @(posedge clock);
        #1;
        done_cnt = 0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clock);
            #1;
            if (k == 3) bin_in = 14'd777;
            if (k == 16) start = 1'b0;
            if (k == 15) begin
                check("busy_ignore first done", {31'd0, done}, 32'd1);
                check("busy_ignore first bcd", {16'd0, bcd}, 32'h0042);
            end else if (k == 16) begin
                check("busy_ignore re-accept busy", {31'd0, busy}, 32'd1);
            end else if (k == 31) begin
                check("busy_ignore second done", {31'd0, done}, 32'd1);
                check("busy_ignore second bcd", {16'd0, bcd}, 32'h0777);
            end else if (done === 1'b1) begin
                done_cnt++;
            end
        end
        check("busy_ignore stray done", done_cnt, 0);
        last_bcd = 16'h0777;
        last_ovf = 1'b0;

        // Reset five cycles into a conversion
        @(negedge clock);
        bin_in = 14'd1234;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset bcd", {16'd0, bcd}, 32'd0);
        check("midreset overflow", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (done === 1'b1) done_cnt++;
        end
        check("midreset no done", done_cnt, 0);
        last_bcd = 16'h0000;
        last_ovf = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            rv = 14'($urandom_range(0, 16383));
            run_conv(rv, ref_bcd(int'(rv)), rv > 14'd9999, 1'b0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
